// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_arbiter
// Description : Two-port (icache/dcache) fair arbiter onto one shared memory
//               port, with latched request and a one-cycle recovery gap.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  icache_pmem_read,
    input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
    output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
    output logic                  icache_pmem_resp,
    input  logic                  dcache_pmem_read,
    input  logic                  dcache_pmem_write,
    input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
    input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
    output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
    output logic                  dcache_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RECOVER = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE   = 2'd0,
        OP_IREAD  = 2'd1,
        OP_DREAD  = 2'd2,
        OP_DWRITE = 2'd3
    } op_t;

    localparam logic c_grant_i = 1'b0;
    localparam logic c_grant_d = 1'b1;

    state_t r_state;
    op_t    r_op;
    logic   r_last_grant;

    logic w_i_req;
    logic w_d_req;
    logic w_grant_d;
    logic w_serve_i;
    logic w_serve_d;

    assign w_i_req   = icache_pmem_read;
    assign w_d_req   = dcache_pmem_read | dcache_pmem_write;
    // On a tie the port that was not served last wins.
    assign w_grant_d = w_d_req & (~w_i_req | (r_last_grant == c_grant_i));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_op         <= OP_NONE;
            r_last_grant <= c_grant_i;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state      <= SERVE_D;
                        pmem_address <= dcache_pmem_address;
                        // A simultaneous read+write request is a writeback.
                        if (dcache_pmem_write) begin
                            r_op       <= OP_DWRITE;
                            pmem_write <= 1'b1;
                            pmem_wdata <= dcache_pmem_wdata;
                        end else begin
                            r_op      <= OP_DREAD;
                            pmem_read <= 1'b1;
                        end
                    end else if (w_i_req) begin
                        r_state      <= SERVE_I;
                        r_op         <= OP_IREAD;
                        pmem_address <= icache_pmem_address;
                        pmem_read    <= 1'b1;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        r_state      <= RECOVER;
                        pmem_read    <= 1'b0;
                        pmem_write   <= 1'b0;
                        r_last_grant <= (r_op == OP_IREAD) ? c_grant_i : c_grant_d;
                    end
                end
                RECOVER: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_serve_i = (r_state == SERVE_I);
    assign w_serve_d = (r_state == SERVE_D);

    assign icache_pmem_resp  = w_serve_i & pmem_resp;
    assign dcache_pmem_resp  = w_serve_d & pmem_resp;
    assign icache_pmem_rdata = w_serve_i ? pmem_rdata : '0;
    assign dcache_pmem_rdata = w_serve_d ? pmem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_arbiter
// Description : Scoreboard bench for cache_arbiter; the bench plays memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_arbiter;

    logic         clk;
    logic         reset_n;
    logic         icache_pmem_read;
    logic [15:0]  icache_pmem_address;
    logic [127:0] icache_pmem_rdata;
    logic         icache_pmem_resp;
    logic         dcache_pmem_read;
    logic         dcache_pmem_write;
    logic [15:0]  dcache_pmem_address;
    logic [127:0] dcache_pmem_wdata;
    logic [127:0] dcache_pmem_rdata;
    logic         dcache_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit           is_d;
        logic [127:0] data;
    } sb_t;
    sb_t sb_q[$];
    sb_t m_e;

    cache_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .icache_pmem_read    (icache_pmem_read),
        .icache_pmem_address (icache_pmem_address),
        .icache_pmem_rdata   (icache_pmem_rdata),
        .icache_pmem_resp    (icache_pmem_resp),
        .dcache_pmem_read    (dcache_pmem_read),
        .dcache_pmem_write   (dcache_pmem_write),
        .dcache_pmem_address (dcache_pmem_address),
        .dcache_pmem_wdata   (dcache_pmem_wdata),
        .dcache_pmem_rdata   (dcache_pmem_rdata),
        .dcache_pmem_resp    (dcache_pmem_resp),
        .pmem_read           (pmem_read),
        .pmem_write          (pmem_write),
        .pmem_address        (pmem_address),
        .pmem_wdata          (pmem_wdata),
        .pmem_rdata          (pmem_rdata),
        .pmem_resp           (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every resp pulse the DUT presents must match the head of the queue.
    always @(negedge clk) begin
        if (icache_pmem_resp || dcache_pmem_resp) begin
            if (sb_q.size() == 0) begin
                check("unexpected_resp", {126'd0, icache_pmem_resp, dcache_pmem_resp}, '0);
            end else begin
                m_e = sb_q.pop_front();
                check("resp_port", {126'd0, icache_pmem_resp, dcache_pmem_resp},
                      m_e.is_d ? 128'd1 : 128'd2);
                check("resp_data", m_e.is_d ? dcache_pmem_rdata : icache_pmem_rdata, m_e.data);
            end
        end
    end

    // Waits for the memory strobe, checks it, optionally disturbs the served
    // port's inputs, then answers with one pmem_resp pulse.
    task automatic serve(input string name, input bit exp_d, input bit exp_wr,
                         input logic [15:0] exp_addr, input logic [127:0] exp_wdata,
                         input logic [127:0] rdata, input int exp_lat, input bit mid_change);
        int  lat  = 0;
        bit  seen = 0;
        sb_t e;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (pmem_read || pmem_write) begin
                seen = 1;
                break;
            end
            lat++;
        end
        if (!seen) begin
            fails++; tests++;
            $display("FAIL %s_timeout: got no strobe expected strobe within 20 cycles", name);
            return;
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_read"},    pmem_read,  !exp_wr);
        check({name, "_write"},   pmem_write, exp_wr);
        check({name, "_addr"},    pmem_address, exp_addr);
        if (exp_wr) check({name, "_wdata"}, pmem_wdata, exp_wdata);
        if (mid_change) begin
            if (exp_d) begin
                dcache_pmem_address = 16'hFFF0;
                dcache_pmem_wdata   = ~exp_wdata;
            end else begin
                icache_pmem_address = 16'hFFF0;
                icache_pmem_read    = 1'b0;
            end
        end
        @(posedge clk); #1;
        check({name, "_hold_strobe"}, {pmem_read, pmem_write}, {!exp_wr, exp_wr});
        check({name, "_hold_addr"},   pmem_address, exp_addr);
        if (exp_wr) check({name, "_hold_wdata"}, pmem_wdata, exp_wdata);
        e.is_d = exp_d;
        e.data = rdata;
        sb_q.push_back(e);
        pmem_rdata = rdata;
        pmem_resp  = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        if (exp_d) begin
            dcache_pmem_read  = 1'b0;
            dcache_pmem_write = 1'b0;
        end else begin
            icache_pmem_read = 1'b0;
        end
        check({name, "_recover_idle_strobe"}, {pmem_read, pmem_write}, 2'b00);
    endtask

    initial begin
        bit seen;
        reset_n = 1'b0;
        icache_pmem_read = 1'b0; icache_pmem_address = '0;
        dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
        dcache_pmem_address = '0; dcache_pmem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;

        #2;
        check("rst_read",  pmem_read, 0);
        check("rst_write", pmem_write, 0);
        check("rst_addr",  pmem_address, 0);
        check("rst_wdata", pmem_wdata, 0);
        check("rst_resps", {icache_pmem_resp, dcache_pmem_resp}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Icache alone; request dropped and address changed mid-service.
        icache_pmem_read = 1'b1; icache_pmem_address = 16'h1230;
        serve("icache_alone", 0, 0, 16'h1230, '0, {16{8'hA5}}, 0, 1);

        // Dcache writeback; address/wdata changed mid-service.
        dcache_pmem_write = 1'b1; dcache_pmem_address = 16'h4000;
        dcache_pmem_wdata = 128'h0123456789ABCDEF_FEDCBA9876543210;
        serve("dcache_write", 1, 1, 16'h4000, 128'h0123456789ABCDEF_FEDCBA9876543210,
              128'h0, 1, 1);

        // Read and write together is a write.
        dcache_pmem_read = 1'b1; dcache_pmem_write = 1'b1; dcache_pmem_address = 16'h5550;
        dcache_pmem_wdata = 128'hDEADBEEF_00000000_CAFEF00D_11111111;
        serve("dcache_rw", 1, 1, 16'h5550, 128'hDEADBEEF_00000000_CAFEF00D_11111111,
              128'h77, 1, 0);

        // Stray resp in IDLE.
        @(posedge clk); #1;
        pmem_rdata = 128'h5A; pmem_resp = 1'b1;
        #1;
        check("stray_idle_resps", {icache_pmem_resp, dcache_pmem_resp}, 0);
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        check("stray_idle_strobe", {pmem_read, pmem_write}, 0);
        icache_pmem_read = 1'b1; icache_pmem_address = 16'h2220;
        serve("after_stray", 0, 0, 16'h2220, '0, 128'h2468, 0, 0);

        // Reset pulse during SERVE_I, then a late pmem_resp.
        icache_pmem_read = 1'b1; icache_pmem_address = 16'h7770;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (pmem_read) begin seen = 1; break; end
        end
        check("midrst_strobe_seen", seen, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_async_read", pmem_read, 0);
        check("midrst_async_addr", pmem_address, 0);
        icache_pmem_read = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        pmem_rdata = 128'h99; pmem_resp = 1'b1;
        #1;
        check("midrst_late_resp", {icache_pmem_resp, dcache_pmem_resp}, 0);
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        check("midrst_late_strobe", {pmem_read, pmem_write}, 0);

        // Ties from reset: dcache, icache, dcache.
        icache_pmem_read = 1'b1; icache_pmem_address = 16'h1000;
        dcache_pmem_read = 1'b1; dcache_pmem_address = 16'h2000;
        serve("tie1_d", 1, 0, 16'h2000, '0, 128'h1, 0, 0);
        dcache_pmem_read = 1'b1;
        serve("tie2_i", 0, 0, 16'h1000, '0, 128'h2, 1, 0);
        icache_pmem_read = 1'b1;
        serve("tie3_d", 1, 0, 16'h2000, '0, 128'h3, 1, 0);
        serve("tail_i", 0, 0, 16'h1000, '0, 128'h4, 1, 0);

        @(posedge clk); #1;
        check("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
